lsu_bus_master: RTL and testbench
=================================

LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, cycles from request accept to forced abort (1..255).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have core-side ports: req_valid in 1; req_ready out 1; req_wen in 1 (1=store); req_addr in 32; req_wdata in 32; req_wstrb in 4; req_size in 4 (byte count 1/2/4); req_unsign in 1 (zero-extend loads).
REQ-005 SHALL have response ports: resp_valid out 1 (one-cycle pulse); resp_rdata out 32; resp_err out 1.
REQ-006 SHALL have AR/R ports: arvalid out 1; araddr out 32; arsize out 4; load_unsign out 1; arready in 1; rvalid in 1; rdata in 32; rresp in 1 (1=OK); rready out 1.
REQ-007 SHALL have AW/W/B ports: awvalid out 1; awaddr out 32; awready in 1; wvalid out 1; wdata out 32; wstrb out 32 (bits [31:4] driven 0); wready in 1; bvalid in 1; bresp in 1 (ignored); bready out 1.

Function
REQ-008 SHALL implement FSM states IDLE, RD, WR, WB, RESP.
REQ-009 SHALL drive req_ready=1 only in IDLE; request accepted on req_valid&&req_ready.
REQ-010 SHALL check on accept: size not in {1,2,4}, or size 2 with addr[0]=1, or size 4 with addr[1:0]!=0 -> no bus activity, go to RESP with resp_err=1, resp_rdata=0.
REQ-011 SHALL register addr/size/unsign/wdata/wstrb on accept; araddr, awaddr, wdata, wstrb SHALL hold stable from accept until return to IDLE.
REQ-012 SHALL in RD assert arvalid and rready together from the first RD cycle; arvalid drops after the cycle where arvalid&&arready; rready stays 1 until rvalid&&rready.
REQ-013 SHALL on rvalid&&rready capture rdata into resp_rdata, set resp_err=!rresp, go to RESP.
REQ-014 SHALL in WR assert awvalid and wvalid in the same first cycle; each drops independently after its own handshake (awvalid&&awready, wvalid&&wready); enter WB when both done, including when both occur in the same cycle.
REQ-015 SHALL in WB assert bready; on bvalid&&bready go to RESP with resp_err=0, resp_rdata unchanged.
REQ-016 SHALL in RESP assert resp_valid for exactly one cycle, then return to IDLE; resp_rdata/resp_err hold until the next RESP.
REQ-017 SHALL run a watchdog counter cleared on accept, counting in RD/WR/WB; at TIMEOUT_CYCLES drop all bus valids/readies, go to RESP with resp_err=1.
REQ-018 SHALL leave minimum load latency at 3 cycles accept-to-resp_valid (slave with arready=1, rvalid next cycle).
REQ-019 SHALL ignore rvalid/bvalid arriving in IDLE or RESP (no response generated).
REQ-020 SHALL never have a read and a write outstanding simultaneously.

Reset
REQ-021 SHALL on reset assertion immediately force state IDLE, all valid/ready/resp outputs 0, resp_rdata 0, watchdog 0, address/data registers 0.
REQ-022 SHALL on reset mid-transaction drop the transaction without a response; first request accepted the cycle after reset deasserts.

Structure
REQ-023 SHALL place FSM state enum, size encodings (SZ_B=1, SZ_H=2, SZ_W=4) and response code constants in shared package lsu_bus_pkg.
REQ-024 SHALL implement the watchdog as sub-module lsu_bus_watchdog (clear, enable, expired).

Verification
REQ-025 Load word: req addr 0x80000004 size 4 unsign 0, slave returns 0xDEADBEEF rresp=1 -> arsize=4, resp_valid once, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-026 Store: addr 0x80000010 wdata 0x12345678 wstrb 0xF, awready delayed 2 cycles, wready after 1 -> awaddr/wdata stable throughout, bready after both handshakes, resp_err=0.
REQ-027 Misaligned: size 4 addr 0x80000002 -> no arvalid/awvalid ever, resp_valid with resp_err=1 on the 2nd cycle after accept.
REQ-028 Timeout: TIMEOUT_CYCLES=8, slave never asserts rvalid -> arvalid/rready drop and resp_err=1 resp_valid at cycle 8 after accept.
REQ-029 Reset mid-write: assert reset while wvalid=1 -> wvalid/awvalid/bready 0 same cycle, no resp_valid, next request served normally.
REQ-030 Back-to-back: two loads issued on consecutive req_ready cycles -> two distinct resp_valid pulses, no overlapping arvalid.

Source files
------------

// File: rtl/lsu_bus_pkg.sv
// Shared types and constants for the LSU bus master and its watchdog.
package lsu_bus_pkg;

    // Transaction FSM states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        WB   = 3'd3,
        RESP = 3'd4
    } lsu_state_e;

    // Access size encodings (byte count)
    localparam logic [3:0] SZ_B = 4'd1;
    localparam logic [3:0] SZ_H = 4'd2;
    localparam logic [3:0] SZ_W = 4'd4;

    // Bus read response code meaning success
    localparam logic RRESP_OK = 1'b1;

    // Core-side response error codes
    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

    // Watchdog counter width; covers TIMEOUT_CYCLES up to 255
    localparam int unsigned WDOG_W = 8;

    // Unsupported size or an address not aligned to the access size
    function automatic logic req_is_illegal(input logic [3:0] size,
                                            input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_bus_watchdog.sv
// Transaction watchdog: counts enabled cycles since the last clear and
// flags expiry on the TIMEOUT_CYCLES-th enabled cycle.
module lsu_bus_watchdog
    import lsu_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;

    assign expired_o = enable_i && (cnt_q == LAST);

    // Next count: clear wins, otherwise advance while enabled and not expired
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lsu_bus_master.sv
// LSU bus master: turns single core load/store requests into one AR/R or
// AW/W/B bus transaction, with size/alignment checking and a watchdog.
module lsu_bus_master
    import lsu_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    // core request
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    input  logic [3:0]  req_size,
    input  logic        req_unsign,
    // core response
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    // read address / data
    output logic        arvalid,
    output logic [31:0] araddr,
    output logic [3:0]  arsize,
    output logic        load_unsign,
    input  logic        arready,
    input  logic        rvalid,
    input  logic [31:0] rdata,
    input  logic        rresp,
    output logic        rready,
    // write address / data / response
    output logic        awvalid,
    output logic [31:0] awaddr,
    input  logic        awready,
    output logic        wvalid,
    output logic [31:0] wdata,
    output logic [31:0] wstrb,
    input  logic        wready,
    input  logic        bvalid,
    input  logic        bresp,
    output logic        bready
);

    lsu_state_e  state_q;
    logic        req_ready_q;
    logic [31:0] addr_q;
    logic [3:0]  size_q;
    logic        unsign_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        accept;
    logic        wd_enable;
    logic        wd_expired;
    logic        aw_pending;
    logic        w_pending;

    // Write responses are never reported as errors, so bresp has no effect
    logic        unused_bresp;
    assign unused_bresp = bresp;

    assign accept     = (state_q == IDLE) && req_ready_q && req_valid;
    assign wd_enable  = (state_q == RD) || (state_q == WR) || (state_q == WB);

    // A channel is still pending if its valid is up and not handshaking now
    assign aw_pending = awvalid_q && !awready;
    assign w_pending  = wvalid_q && !wready;

    lsu_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clk),
        .rst_i     (reset),
        .clear_i   (accept),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );

    // Transaction FSM with all bus and response outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            unsign_q     <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        addr_q      <= req_addr;
                        size_q      <= req_size;
                        unsign_q    <= req_unsign;
                        wdata_q     <= req_wdata;
                        wstrb_q     <= req_wstrb;
                        if (req_is_illegal(req_size, req_addr[1:0])) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= RESP_ERR;
                            resp_rdata_q <= '0;
                        end else if (req_wen) begin
                            state_q   <= WR;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= RD;
                            arvalid_q <= 1'b1;
                            rready_q  <= 1'b1;
                        end
                    end
                end

                RD: begin
                    // A real read response takes priority over a same-cycle timeout
                    if (rvalid && rready_q) begin
                        arvalid_q    <= 1'b0;
                        rready_q     <= 1'b0;
                        resp_rdata_q <= rdata;
                        resp_err_q   <= (rresp != RRESP_OK);
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else if (wd_expired) begin
                        arvalid_q    <= 1'b0;
                        rready_q     <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= RESP_ERR;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else if (arvalid_q && arready) begin
                        arvalid_q <= 1'b0;
                    end
                end

                WR: begin
                    // Both channels done (now or earlier) moves on, even if simultaneous
                    if (!aw_pending && !w_pending) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= WB;
                    end else if (wd_expired) begin
                        awvalid_q    <= 1'b0;
                        wvalid_q     <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= RESP_ERR;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        if (awvalid_q && awready) begin
                            awvalid_q <= 1'b0;
                        end
                        if (wvalid_q && wready) begin
                            wvalid_q <= 1'b0;
                        end
                    end
                end

                WB: begin
                    if (bvalid && bready_q) begin
                        bready_q     <= 1'b0;
                        resp_err_q   <= RESP_OK;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else if (wd_expired) begin
                        bready_q     <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= RESP_ERR;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end

                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign arvalid     = arvalid_q;
    assign araddr      = addr_q;
    assign arsize      = size_q;
    assign load_unsign = unsign_q;
    assign rready      = rready_q;
    assign awvalid     = awvalid_q;
    assign awaddr      = addr_q;
    assign wvalid      = wvalid_q;
    assign wdata       = wdata_q;
    assign wstrb       = {28'b0, wstrb_q};
    assign bready      = bready_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed testbench for lsu_bus_master (TIMEOUT_CYCLES = 8).
// Timing notation: k = number of rising edges after the accept edge at the
// moment of sampling (1 time unit after that edge).
module tb_lsu_bus_master;
    import lsu_bus_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [3:0]  req_size;
    logic        req_unsign;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arsize;
    logic        load_unsign;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rresp;
    logic        rready;
    logic        awvalid;
    logic [31:0] awaddr;
    logic        awready;
    logic        wvalid;
    logic [31:0] wdata;
    logic [31:0] wstrb;
    logic        wready;
    logic        bvalid;
    logic        bresp;
    logic        bready;

    int unsigned vectors;
    int unsigned miscompares;
    int unsigned resp_cnt;

    lsu_bus_master #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wen     (req_wen),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .req_size    (req_size),
        .req_unsign  (req_unsign),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .arvalid     (arvalid),
        .araddr      (araddr),
        .arsize      (arsize),
        .load_unsign (load_unsign),
        .arready     (arready),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .rresp       (rresp),
        .rready      (rready),
        .awvalid     (awvalid),
        .awaddr      (awaddr),
        .awready     (awready),
        .wvalid      (wvalid),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .wready      (wready),
        .bvalid      (bvalid),
        .bresp       (bresp),
        .bready      (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle with resp_valid high, sampled mid-cycle
    always @(negedge clk) begin
        if (resp_valid === 1'b1) resp_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) for req_ready, return at k=0
    task automatic issue_req(input logic wen, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] strb,
                             input logic [3:0] size, input logic uns);
        int unsigned n;
        n = 0;
        req_valid  = 1'b1;
        req_wen    = wen;
        req_addr   = addr;
        req_wdata  = wd;
        req_wstrb  = strb;
        req_size   = size;
        req_unsign = uns;
        while (req_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL req_ready_wait: got req_ready=%b after %0d cycles, exp 1", req_ready, n);
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        vectors++;
        if ({req_ready, arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err} !== 8'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, exp 00000000",
                     {req_ready, arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err});
        end
        vectors++;
        if ({resp_rdata, araddr, wdata, wstrb} !== 128'b0) begin
            miscompares++;
            $display("FAIL reset_data: got rdata=%h araddr=%h wdata=%h wstrb=%h, exp all 0",
                     resp_rdata, araddr, wdata, wstrb);
        end
        reset = 1'b0;
        step();
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b, exp 1", req_ready);
        end
    endtask

    task automatic test_load_word();
        arready = 1'b1;
        issue_req(1'b0, 32'h8000_0004, 32'h0, 4'h0, SZ_W, 1'b0);
        // k=0: read issued
        vectors++;
        if ({arvalid, rready, req_ready, araddr, arsize, load_unsign} !== {3'b110, 32'h8000_0004, 4'd4, 1'b0}) begin
            miscompares++;
            $display("FAIL ld_issue: got arvalid=%b rready=%b req_ready=%b araddr=%h arsize=%0d uns=%b, exp 1 1 0 80000004 4 0",
                     arvalid, rready, req_ready, araddr, arsize, load_unsign);
        end
        step();
        // k=1: AR handshake done, still waiting for data
        vectors++;
        if ({arvalid, rready, resp_valid} !== 3'b010) begin
            miscompares++;
            $display("FAIL ld_ar_done: got arvalid=%b rready=%b resp_valid=%b, exp 0 1 0", arvalid, rready, resp_valid);
        end
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 1'b1;
        step();
        rvalid = 1'b0;
        // k=2: response (3 cycles counting the accept cycle)
        vectors++;
        if ({resp_valid, resp_err, rready, resp_rdata} !== {3'b100, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL ld_resp: got valid=%b err=%b rready=%b rdata=%h, exp 1 0 0 deadbeef",
                     resp_valid, resp_err, rready, resp_rdata);
        end
        step();
        vectors++;
        if ({resp_valid, req_ready, resp_rdata} !== {2'b01, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL ld_after: got valid=%b req_ready=%b rdata=%h, exp 0 1 deadbeef",
                     resp_valid, req_ready, resp_rdata);
        end
    endtask

    task automatic test_store();
        awready = 1'b0; wready = 1'b0;
        issue_req(1'b1, 32'h8000_0010, 32'h1234_5678, 4'hF, SZ_W, 1'b0);
        vectors++;
        if ({awvalid, wvalid, bready, awaddr, wdata, wstrb} !== {3'b110, 32'h8000_0010, 32'h1234_5678, 32'h0000_000F}) begin
            miscompares++;
            $display("FAIL st_issue: got aw=%b w=%b b=%b awaddr=%h wdata=%h wstrb=%h, exp 1 1 0 80000010 12345678 0000000f",
                     awvalid, wvalid, bready, awaddr, wdata, wstrb);
        end
        wready = 1'b1;
        step();
        wready = 1'b0;
        // k=1: W done, AW still pending
        vectors++;
        if ({awvalid, wvalid, bready, awaddr, wdata} !== {3'b100, 32'h8000_0010, 32'h1234_5678}) begin
            miscompares++;
            $display("FAIL st_w_done: got aw=%b w=%b b=%b awaddr=%h wdata=%h, exp 1 0 0 80000010 12345678",
                     awvalid, wvalid, bready, awaddr, wdata);
        end
        awready = 1'b1;
        step();
        awready = 1'b0;
        // k=2: both handshakes done, waiting for B
        vectors++;
        if ({awvalid, wvalid, bready, awaddr, wdata} !== {3'b001, 32'h8000_0010, 32'h1234_5678}) begin
            miscompares++;
            $display("FAIL st_b_wait: got aw=%b w=%b b=%b awaddr=%h wdata=%h, exp 0 0 1 80000010 12345678",
                     awvalid, wvalid, bready, awaddr, wdata);
        end
        bvalid = 1'b1; bresp = 1'b0;
        step();
        bvalid = 1'b0;
        vectors++;
        if ({resp_valid, resp_err, bready, resp_rdata} !== {3'b100, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL st_resp: got valid=%b err=%b bready=%b rdata=%h, exp 1 0 0 deadbeef",
                     resp_valid, resp_err, bready, resp_rdata);
        end
        step();
    endtask

    task automatic test_store_same_cycle();
        awready = 1'b1; wready = 1'b1;
        issue_req(1'b1, 32'h0000_0040, 32'hA5A5_0000, 4'hC, SZ_H, 1'b0);
        step();
        awready = 1'b0; wready = 1'b0;
        vectors++;
        if ({awvalid, wvalid, bready, wstrb} !== {3'b001, 32'h0000_000C}) begin
            miscompares++;
            $display("FAIL st_same_cycle: got aw=%b w=%b b=%b wstrb=%h, exp 0 0 1 0000000c",
                     awvalid, wvalid, bready, wstrb);
        end
        bvalid = 1'b1; bresp = 1'b1;
        step();
        bvalid = 1'b0;
        vectors++;
        if ({resp_valid, resp_err} !== 2'b10) begin
            miscompares++;
            $display("FAIL st_same_resp: got valid=%b err=%b, exp 1 0", resp_valid, resp_err);
        end
        step();
    endtask

    task automatic test_misaligned();
        arready = 1'b1; awready = 1'b1; wready = 1'b1;
        // word at addr[1:0]=2: response already at k=0 (second cycle counting accept)
        issue_req(1'b0, 32'h8000_0002, 32'h0, 4'h0, SZ_W, 1'b0);
        vectors++;
        if ({arvalid, awvalid, resp_valid, resp_err, resp_rdata} !== {4'b0011, 32'h0}) begin
            miscompares++;
            $display("FAIL mis_word: got ar=%b aw=%b valid=%b err=%b rdata=%h, exp 0 0 1 1 00000000",
                     arvalid, awvalid, resp_valid, resp_err, resp_rdata);
        end
        step();
        vectors++;
        if ({arvalid, awvalid, resp_valid, req_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL mis_word_after: got ar=%b aw=%b valid=%b ready=%b, exp 0 0 0 1",
                     arvalid, awvalid, resp_valid, req_ready);
        end
        // halfword store at odd address
        issue_req(1'b1, 32'h8000_0011, 32'hFFFF_FFFF, 4'h3, SZ_H, 1'b0);
        vectors++;
        if ({awvalid, wvalid, resp_valid, resp_err} !== 4'b0011) begin
            miscompares++;
            $display("FAIL mis_half_st: got aw=%b w=%b valid=%b err=%b, exp 0 0 1 1",
                     awvalid, wvalid, resp_valid, resp_err);
        end
        step();
        // unsupported size 3
        issue_req(1'b0, 32'h0000_0000, 32'h0, 4'h0, 4'd3, 1'b0);
        vectors++;
        if ({arvalid, resp_valid, resp_err} !== 3'b011) begin
            miscompares++;
            $display("FAIL bad_size: got ar=%b valid=%b err=%b, exp 0 1 1", arvalid, resp_valid, resp_err);
        end
        step();
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
    endtask

    task automatic test_read_error();
        arready = 1'b0;
        issue_req(1'b0, 32'h8000_0006, 32'h0, 4'h0, SZ_H, 1'b1);
        step();
        // k=1: arvalid held while arready low
        vectors++;
        if ({arvalid, rready, arsize, load_unsign} !== {2'b11, 4'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL rderr_hold: got ar=%b r=%b arsize=%0d uns=%b, exp 1 1 2 1",
                     arvalid, rready, arsize, load_unsign);
        end
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h0000_ABCD; rresp = 1'b0;
        step();
        arready = 1'b0; rvalid = 1'b0;
        vectors++;
        if ({resp_valid, resp_err, arvalid, resp_rdata} !== {3'b110, 32'h0000_ABCD}) begin
            miscompares++;
            $display("FAIL rderr_resp: got valid=%b err=%b ar=%b rdata=%h, exp 1 1 0 0000abcd",
                     resp_valid, resp_err, arvalid, resp_rdata);
        end
        step();
    endtask

    task automatic test_timeout();
        arready = 1'b0; rvalid = 1'b0;
        issue_req(1'b0, 32'h8000_0100, 32'h0, 4'h0, SZ_W, 1'b0);
        for (int k = 1; k < 8; k++) begin
            step();
            vectors++;
            if ({arvalid, rready, resp_valid} !== 3'b110) begin
                miscompares++;
                $display("FAIL tmo_wait_k%0d: got ar=%b r=%b valid=%b, exp 1 1 0", k, arvalid, rready, resp_valid);
            end
        end
        step();
        // k=8: forced abort
        vectors++;
        if ({arvalid, rready, resp_valid, resp_err} !== 4'b0011) begin
            miscompares++;
            $display("FAIL tmo_abort: got ar=%b r=%b valid=%b err=%b, exp 0 0 1 1",
                     arvalid, rready, resp_valid, resp_err);
        end
        // late responses in RESP/IDLE are ignored
        rvalid = 1'b1; rresp = 1'b1; rdata = 32'h7777_7777; bvalid = 1'b1;
        step();
        vectors++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL tmo_late1: got valid=%b ready=%b, exp 0 1", resp_valid, req_ready);
        end
        step();
        vectors++;
        if ({resp_valid, resp_rdata} !== {1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL tmo_late2: got valid=%b rdata=%h, exp 0 00000000", resp_valid, resp_rdata);
        end
        rvalid = 1'b0; bvalid = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        int unsigned base;
        awready = 1'b0; wready = 1'b0;
        issue_req(1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'h3, SZ_H, 1'b0);
        vectors++;
        if (wvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre_wvalid: got %b, exp 1", wvalid);
        end
        #1 reset = 1'b1;
        #1;
        vectors++;
        if ({wvalid, awvalid, bready, req_ready, resp_err} !== 5'b0) begin
            miscompares++;
            $display("FAIL rst_async_ctrl: got w=%b aw=%b b=%b ready=%b err=%b, exp 0 0 0 0 0",
                     wvalid, awvalid, bready, req_ready, resp_err);
        end
        vectors++;
        if ({awaddr, wdata} !== 64'b0) begin
            miscompares++;
            $display("FAIL rst_async_data: got awaddr=%h wdata=%h, exp 0 0", awaddr, wdata);
        end
        base = resp_cnt;
        step();
        reset = 1'b0;
        step();
        vectors++;
        if ({req_ready, awvalid, wvalid} !== 3'b100) begin
            miscompares++;
            $display("FAIL rst_release: got ready=%b aw=%b w=%b, exp 1 0 0", req_ready, awvalid, wvalid);
        end
        vectors++;
        if (resp_cnt != base) begin
            miscompares++;
            $display("FAIL rst_no_resp: got %0d responses, exp 0", resp_cnt - base);
        end
        arready = 1'b1;
        issue_req(1'b0, 32'h8000_0008, 32'h0, 4'h0, SZ_W, 1'b0);
        step();
        rvalid = 1'b1; rdata = 32'h5A5A_5A5A; rresp = 1'b1;
        step();
        rvalid = 1'b0;
        vectors++;
        if ({resp_valid, resp_err, resp_rdata} !== {2'b10, 32'h5A5A_5A5A}) begin
            miscompares++;
            $display("FAIL rst_next_load: got valid=%b err=%b rdata=%h, exp 1 0 5a5a5a5a",
                     resp_valid, resp_err, resp_rdata);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int unsigned base;
        base = resp_cnt;
        arready = 1'b1;
        issue_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, SZ_W, 1'b0);
        step();
        rvalid = 1'b1; rdata = 32'h1111_1111; rresp = 1'b1;
        step();
        rvalid = 1'b0;
        vectors++;
        if ({resp_valid, arvalid, resp_rdata} !== {2'b10, 32'h1111_1111}) begin
            miscompares++;
            $display("FAIL b2b_first: got valid=%b ar=%b rdata=%h, exp 1 0 11111111", resp_valid, arvalid, resp_rdata);
        end
        issue_req(1'b0, 32'h0000_0104, 32'h0, 4'h0, SZ_W, 1'b0);
        vectors++;
        if ({arvalid, resp_valid, araddr} !== {2'b10, 32'h0000_0104}) begin
            miscompares++;
            $display("FAIL b2b_second_issue: got ar=%b valid=%b araddr=%h, exp 1 0 00000104", arvalid, resp_valid, araddr);
        end
        step();
        rvalid = 1'b1; rdata = 32'h2222_2222; rresp = 1'b1;
        step();
        rvalid = 1'b0;
        vectors++;
        if ({resp_valid, resp_rdata} !== {1'b1, 32'h2222_2222}) begin
            miscompares++;
            $display("FAIL b2b_second: got valid=%b rdata=%h, exp 1 22222222", resp_valid, resp_rdata);
        end
        step();
        vectors++;
        if (resp_cnt - base != 2) begin
            miscompares++;
            $display("FAIL b2b_pulses: got %0d response cycles, exp 2", resp_cnt - base);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; resp_cnt = 0;
        reset = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
        req_wstrb = '0; req_size = '0; req_unsign = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 1'b0;

        test_reset();
        test_load_word();
        test_store();
        test_store_same_cycle();
        test_misaligned();
        test_read_error();
        test_timeout();
        test_reset_mid_write();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
